// File: rtl/hazard_scoreboard.sv
// Decode-stage RAW hazard detector for the non-forwarding WISC pipeline.
// Tracks in-flight destinations (EX/MEM/WB) and stalls decode until its sources are written.
module hazard_scoreboard #(
  parameter bit BYPASS_RF = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] instr_id,
  input  logic        id_valid,
  input  logic        flush,
  input  logic        mem_stall,
  output logic        stall,
  output logic [15:0] stall_cnt
);

  typedef enum logic [1:0] {FMT_J, FMT_I1, FMT_I2, FMT_R} fmt_e;

  localparam logic [4:0] OP_JAL  = 5'b00110;
  localparam logic [4:0] OP_JALR = 5'b00111;
  localparam logic [4:0] OP_ST   = 5'b10000;
  localparam logic [4:0] OP_STU  = 5'b10011;
  localparam logic [4:0] OP_LBI  = 5'b11000;
  localparam logic [4:0] OP_SLBI = 5'b10010;
  localparam logic [4:0] OP_BTR  = 5'b11001;

  logic [4:0] op;
  logic [2:0] rs;
  logic [2:0] rt;
  fmt_e       fmt;
  logic       src_a_v;
  logic       src_b_v;
  logic       dst_v;
  logic [2:0] dst;
  logic       unused_low_bits;

  assign op              = instr_id[15:11];
  assign rs              = instr_id[10:8];
  assign rt              = instr_id[7:5];
  assign unused_low_bits = ^instr_id[1:0];

  always_comb begin
    fmt = FMT_J;
    case (op)
      5'b01000, 5'b01001, 5'b01010, 5'b01011,
      5'b10100, 5'b10101, 5'b10110, 5'b10111,
      5'b10000, 5'b10001, 5'b10011:            fmt = FMT_I1;
      5'b11000, 5'b10010, 5'b00101, 5'b00111,
      5'b01100, 5'b01101, 5'b01110, 5'b01111:  fmt = FMT_I2;
      5'b11001, 5'b11010, 5'b11011,
      5'b11100, 5'b11101, 5'b11110, 5'b11111:  fmt = FMT_R;
      default:                                 fmt = FMT_J;
    endcase
  end

  // Operand usage and destination per format; undefined opcodes fall into J (no effect).
  always_comb begin
    src_a_v = 1'b0;
    src_b_v = 1'b0;
    dst_v   = 1'b0;
    dst     = rt;
    case (fmt)
      FMT_I1: begin
        src_a_v = 1'b1;
        src_b_v = (op == OP_ST) || (op == OP_STU);
        if (op == OP_STU) begin
          dst_v = 1'b1;
          dst   = rs;
        end else if (op != OP_ST) begin
          dst_v = 1'b1;
          dst   = rt;
        end
      end
      FMT_I2: begin
        src_a_v = (op != OP_LBI);
        if ((op == OP_LBI) || (op == OP_SLBI)) begin
          dst_v = 1'b1;
          dst   = rs;
        end else if (op == OP_JALR) begin
          dst_v = 1'b1;
          dst   = 3'd7;
        end
      end
      FMT_R: begin
        src_a_v = 1'b1;
        src_b_v = (op != OP_BTR);
        dst_v   = 1'b1;
        dst     = instr_id[4:2];
      end
      default: begin
        if (op == OP_JAL) begin
          dst_v = 1'b1;
          dst   = 3'd7;
        end
      end
    endcase
  end

  logic       ex_v_q,  ex_v_d;
  logic [2:0] ex_r_q,  ex_r_d;
  logic       mem_v_q, mem_v_d;
  logic [2:0] mem_r_q, mem_r_d;
  logic       wb_v_q,  wb_v_d;
  logic [2:0] wb_r_q,  wb_r_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  logic hit_a;
  logic hit_b;
  logic wb_chk;

  // With a bypassing register file the WB write is visible to decode in the same cycle.
  assign wb_chk = wb_v_q && !BYPASS_RF;

  assign hit_a = src_a_v && ((ex_v_q && (ex_r_q == rs)) ||
                             (mem_v_q && (mem_r_q == rs)) ||
                             (wb_chk && (wb_r_q == rs)));
  assign hit_b = src_b_v && ((ex_v_q && (ex_r_q == rt)) ||
                             (mem_v_q && (mem_r_q == rt)) ||
                             (wb_chk && (wb_r_q == rt)));

  assign stall     = id_valid && !flush && (hit_a || hit_b);
  assign stall_cnt = stall_cnt_q;

  always_comb begin
    ex_v_d      = ex_v_q;
    ex_r_d      = ex_r_q;
    mem_v_d     = mem_v_q;
    mem_r_d     = mem_r_q;
    wb_v_d      = wb_v_q;
    wb_r_d      = wb_r_q;
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
    if (!mem_stall) begin
      wb_v_d  = mem_v_q;
      wb_r_d  = mem_r_q;
      mem_v_d = ex_v_q;
      mem_r_d = ex_r_q;
      ex_v_d  = id_valid && !flush && !stall && dst_v;
      ex_r_d  = dst;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_v_q      <= 1'b0;
      ex_r_q      <= 3'd0;
      mem_v_q     <= 1'b0;
      mem_r_q     <= 3'd0;
      wb_v_q      <= 1'b0;
      wb_r_q      <= 3'd0;
      stall_cnt_q <= 16'd0;
    end else begin
      ex_v_q      <= ex_v_d;
      ex_r_q      <= ex_r_d;
      mem_v_q     <= mem_v_d;
      mem_r_q     <= mem_r_d;
      wb_v_q      <= wb_v_d;
      wb_r_q      <= wb_r_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: two instances (bypassing / non-bypassing register file)
// driven in lockstep and compared against an in-flight producer list model.
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] instr_id;
  logic        id_valid;
  logic        flush;
  logic        mem_stall;
  logic        stall_b1, stall_b0;
  logic [15:0] cnt_b1, cnt_b0;

  always #5 clk = ~clk;

  hazard_scoreboard #(.BYPASS_RF(1'b1)) dut_byp (
    .clk(clk), .rst(rst), .instr_id(instr_id), .id_valid(id_valid),
    .flush(flush), .mem_stall(mem_stall), .stall(stall_b1), .stall_cnt(cnt_b1)
  );

  hazard_scoreboard #(.BYPASS_RF(1'b0)) dut_nobyp (
    .clk(clk), .rst(rst), .instr_id(instr_id), .id_valid(id_valid),
    .flush(flush), .mem_stall(mem_stall), .stall(stall_b0), .stall_cnt(cnt_b0)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference decode: which registers an instruction reads, and which it writes.
  function automatic logic [7:0] reads_of(input logic [15:0] i);
    logic [4:0] op;
    logic [7:0] ra, rb;
    op = i[15:11];
    ra = 8'd1 << i[10:8];
    rb = 8'd1 << i[7:5];
    case (op)
      5'b01000, 5'b01001, 5'b01010, 5'b01011,
      5'b10100, 5'b10101, 5'b10110, 5'b10111, 5'b10001: return ra;      // imm ALU, LD
      5'b10000, 5'b10011:                                 return ra | rb; // ST, STU
      5'b10010, 5'b00101, 5'b00111,
      5'b01100, 5'b01101, 5'b01110, 5'b01111:             return ra;      // SLBI, JR, JALR, branches
      5'b11001:                                           return ra;      // BTR
      5'b11010, 5'b11011, 5'b11100, 5'b11101,
      5'b11110, 5'b11111:                                 return ra | rb;
      default:                                            return 8'd0;    // LBI, J-format, undefined
    endcase
  endfunction

  function automatic int writes_of(input logic [15:0] i);
    case (i[15:11])
      5'b01000, 5'b01001, 5'b01010, 5'b01011,
      5'b10100, 5'b10101, 5'b10110, 5'b10111, 5'b10001: return int'(i[7:5]);
      5'b10011, 5'b11000, 5'b10010:                       return int'(i[10:8]);
      5'b00110, 5'b00111:                                 return 7;
      5'b11001, 5'b11010, 5'b11011, 5'b11100,
      5'b11101, 5'b11110, 5'b11111:                       return int'(i[4:2]);
      default:                                            return -1;
    endcase
  endfunction

  // Per instance: list of producers still being written, with their age (1=EX, 2=MEM, 3=WB).
  bit ent_v   [2][4];
  int ent_r   [2][4];
  int ent_age [2][4];
  int mcnt    [2];

  function automatic bit exp_stall(input int b, input logic [15:0] i, input logic v, input logic fl);
    logic [7:0] rm;
    int lim;
    if (!v || fl) return 1'b0;
    rm  = reads_of(i);
    lim = (b == 0) ? 2 : 3;
    for (int k = 0; k < 4; k++)
      if (ent_v[b][k] && ent_age[b][k] <= lim && rm[ent_r[b][k]]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_clear();
    for (int b = 0; b < 2; b++) begin
      mcnt[b] = 0;
      for (int k = 0; k < 4; k++) ent_v[b][k] = 1'b0;
    end
  endtask

  task automatic model_edge(input logic r, input logic [15:0] i, input logic v,
                            input logic fl, input logic ms, input bit es0, input bit es1);
    bit es;
    int w;
    if (r) begin
      model_clear();
      return;
    end
    w = writes_of(i);
    for (int b = 0; b < 2; b++) begin
      es = (b == 0) ? es0 : es1;
      if (es && mcnt[b] < 65535) mcnt[b]++;
      if (!ms) begin
        for (int k = 0; k < 4; k++)
          if (ent_v[b][k]) begin
            ent_age[b][k]++;
            if (ent_age[b][k] > 3) ent_v[b][k] = 1'b0;
          end
        if (v && !fl && !es && w >= 0) begin
          for (int k = 0; k < 4; k++)
            if (!ent_v[b][k]) begin
              ent_v[b][k]   = 1'b1;
              ent_r[b][k]   = w;
              ent_age[b][k] = 1;
              break;
            end
        end
      end
    end
  endtask

  // One decode cycle: drive, check at the falling edge, advance the model at the rising edge.
  task automatic step(input logic r, input logic [15:0] i, input logic v,
                      input logic fl, input logic ms);
    bit es0, es1;
    rst = r; instr_id = i; id_valid = v; flush = fl; mem_stall = ms;
    @(negedge clk);
    es0 = exp_stall(0, i, v, fl);
    es1 = exp_stall(1, i, v, fl);
    chk("stall_byp1", stall_b1, es0);
    chk("stall_byp0", stall_b0, es1);
    chk("cnt_byp1", cnt_b1, mcnt[0]);
    chk("cnt_byp0", cnt_b0, mcnt[1]);
    @(posedge clk);
    model_edge(r, i, v, fl, ms, es0, es1);
    #1;
  endtask

  task automatic do_reset();
    step(1'b1, 16'h0800, 1'b1, 1'b0, 1'b0);
  endtask

  localparam logic [15:0] NOP   = 16'h0800;
  localparam logic [15:0] ADDI  = 16'h4225;  // ADDI R1,R2,5
  localparam logic [15:0] ADD   = 16'hD94C;  // ADD  R3,R1,R2
  localparam logic [15:0] LD    = 16'h8980;  // LD   R4,R1,0
  localparam logic [15:0] USER4 = 16'h4420;  // ADDI R1,R4,0
  localparam logic [15:0] JAL   = 16'h3000;
  localparam logic [15:0] JR7   = 16'h2F00;

  initial begin
    logic [15:0] ri;
    rst = 1'b1; instr_id = NOP; id_valid = 1'b1; flush = 1'b0; mem_stall = 1'b0;
    @(posedge clk);
    #1;
    model_clear();

    // Reset with a NOP in decode.
    do_reset();
    chk("rst_stall", stall_b1, 1'b0);
    chk("rst_cnt", cnt_b1, 16'd0);

    // Back-to-back RAW: 2 stalls with bypass, 3 without.
    step(1'b0, ADDI, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) step(1'b0, ADD, 1'b1, 1'b0, 1'b0);
    step(1'b0, NOP, 1'b1, 1'b0, 1'b0);
    chk("raw1_cnt_byp1", cnt_b1, 16'd2);
    chk("raw1_cnt_byp0", cnt_b0, 16'd3);

    // Distance 2 after a load.
    do_reset();
    step(1'b0, LD, 1'b1, 1'b0, 1'b0);
    step(1'b0, NOP, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) step(1'b0, USER4, 1'b1, 1'b0, 1'b0);
    step(1'b0, NOP, 1'b1, 1'b0, 1'b0);
    chk("raw2_cnt_byp1", cnt_b1, 16'd1);
    chk("raw2_cnt_byp0", cnt_b0, 16'd2);

    // JAL then JR R7, squashed on the first hazard cycle.
    do_reset();
    step(1'b0, JAL, 1'b1, 1'b0, 1'b0);
    step(1'b0, JR7, 1'b1, 1'b1, 1'b0);
    chk("flush_stall", stall_b1 | stall_b0, 1'b0);
    for (int k = 0; k < 3; k++) step(1'b0, JR7, 1'b1, 1'b0, 1'b0);
    step(1'b0, NOP, 1'b1, 1'b0, 1'b0);
    chk("jr_cnt_byp1", cnt_b1, 16'd1);
    chk("jr_cnt_byp0", cnt_b0, 16'd2);

    // Memory freeze during a pending hazard.
    do_reset();
    step(1'b0, ADDI, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) step(1'b0, ADD, 1'b1, 1'b0, 1'b1);
    chk("frz_cnt_byp1", cnt_b1, 16'd4);
    for (int k = 0; k < 4; k++) step(1'b0, ADD, 1'b1, 1'b0, 1'b0);
    step(1'b0, NOP, 1'b1, 1'b0, 1'b0);
    chk("frz_cnt_byp1_end", cnt_b1, 16'd6);
    chk("frz_cnt_byp0_end", cnt_b0, 16'd7);

    // Random traffic over a small register set to make hazards frequent.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      ri = 16'($urandom) & 16'hFB6F;
      step($urandom_range(0, 99) == 0, ri, $urandom_range(0, 9) != 0,
           $urandom_range(0, 9) == 0, $urandom_range(0, 99) < 15);
    end

    // Counter saturation, then reset in the middle of a stall.
    do_reset();
    step(1'b0, ADDI, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 16'hFFFE; k++) step(1'b0, ADD, 1'b1, 1'b0, 1'b1);
    chk("sat_pre_byp1", cnt_b1, 16'hFFFE);
    chk("sat_pre_byp0", cnt_b0, 16'hFFFE);
    for (int k = 0; k < 3; k++) step(1'b0, ADD, 1'b1, 1'b0, 1'b1);
    chk("sat_byp1", cnt_b1, 16'hFFFF);
    chk("sat_byp0", cnt_b0, 16'hFFFF);
    step(1'b1, ADD, 1'b1, 1'b0, 1'b1);
    chk("rst_mid_cnt", cnt_b1, 16'd0);
    step(1'b0, ADD, 1'b1, 1'b0, 1'b0);
    chk("rst_mid_stall_byp1", stall_b1, 1'b0);
    chk("rst_mid_stall_byp0", stall_b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
